bit_serializer: RTL
===================

Name: bit_serializer

Overview:
Parallel-to-serial front end for the bit-stream sequence detectors in this codebase. It accepts WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO. It shifts them out one bit per clock on ser_bit, with ser_valid qualifying each bit. ser_bit drives the detector's serial input x directly; back-to-back words produce a gap-free bit stream.

Parameters:
WIDTH, 8, word width in bits (>=2)
DEPTH, 4, FIFO depth in words (power of 2, >=2)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
IDLE_BIT, 0, value driven on ser_bit whenever ser_valid=0

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_data  in  WIDTH  word to serialize
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept; transfer when in_valid&&in_ready
enable  in  1  shift enable; low pauses the output stream
flush  in  1  synchronous clear of FIFO and current word
ser_bit  out  1  serial data bit (feeds detector x)
ser_valid  out  1  ser_bit carries a data bit this cycle
busy  out  1  shifter holds an unfinished word
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async): FIFO empty, level=0, in_ready=1, state=IDLE, ser_valid=0, ser_bit=IDLE_BIT, busy=0, bit counter=0.
- FIFO: in_ready = (level<DEPTH) && !flush. Push on in_valid&&in_ready. There is no pass-through when full. Pointers wrap modulo DEPTH. Simultaneous push and pop is allowed when 0<level<DEPTH; level is unchanged.
- FSM states: IDLE (no word in shifter) and SHIFT (word loaded, bit counter = bits remaining).
- IDLE -> SHIFT at an edge where level>0 && enable && !flush. This pops the head into the shift register and sets the counter to WIDTH.
- SHIFT, enable=1: ser_valid=1 and ser_bit = current bit (MSB or LSB per MSB_FIRST). At the edge, the shift register advances and the counter decrements.
- Last bit (counter=1) with level>0 && enable: pop the next word at the same edge and stay in SHIFT. Zero-gap streaming is required.
- Last bit with level=0: go to IDLE.
- SHIFT, enable=0: ser_valid=0, ser_bit=IDLE_BIT. Shift register and counter hold, and no pop occurs. Resume with the same bit when enable returns.
- Latency: a word pushed at edge t into an empty FIFO with an idle shifter is popped at edge t+1. Its first bit is valid in the cycle following t+1. A word is WIDTH valid cycles long.
- busy=1 in SHIFT; level reflects the registered occupancy.
- flush=1 (sync, highest priority after reset):
  - FIFO is emptied and the shifter is aborted; state=IDLE at the next edge.
  - ser_valid=0 from the next cycle.
  - A push in the same cycle is dropped; in_ready is already 0 during flush.
- Reset mid-word: outputs return to reset values immediately and the partial word is discarded.
- ser_valid=0 always forces ser_bit=IDLE_BIT, so the downstream detector sees a defined idle level.

Decomposition:
- Package bit_serializer_pkg: FSM state enum (IDLE, SHIFT); helper constants for counter and pointer widths ($clog2(WIDTH)+1, $clog2(DEPTH)).
- One sub-module, sync_fifo: parameters WIDTH and DEPTH; push/pop/flush inputs; level, full and empty outputs.
- The top level holds the FSM, shift register and bit counter.

Test Plan:
1. Reset: hold rst=0 with in_valid=1 -> in_ready=1, ser_valid=0, ser_bit=0, level=0, busy=0. No push is recorded after release until the first active edge.
2. Single word: push 8'hB0 (MSB_FIRST=1, enable=1) -> ser_valid high 8 cycles starting 2 cycles after the push cycle. ser_bit sequence is 1,0,1,1,0,0,0,0, then ser_valid=0.
3. Streaming: push 8'hA5, 8'h5A, 8'hFF, 8'h00 back-to-back -> 32 consecutive valid bits with no gap. level peaks at 3 (one word already popped), in_ready stays 1. Push 6 words while enable=0 -> in_ready=0 once level=4.
4. Pause: enable=0 for 3 cycles after the 3rd bit of 8'hB0 -> ser_valid=0 and ser_bit=0 for 3 cycles. Then the remaining bits 1,0,0,0,0 follow with none lost or repeated.
5. Flush: flush=1 for 1 cycle mid-word with 2 words queued -> the next cycle shows ser_valid=0, level=0, busy=0, in_ready=1. A word pushed afterwards serializes normally.
6. Async reset mid-word: drop rst between clock edges during bit 4 -> ser_valid, busy and level clear without waiting for clk. After release, a fresh push of 8'hC3 produces 1,1,0,0,0,0,1,1.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared constants and width helpers for the bit serializer and its FIFO.
package bit_serializer_pkg;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width) + 1;
  endfunction

  function automatic int unsigned ptr_width(int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with combinational head output and synchronous flush.
module sync_fifo
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  input  logic                        flush,
  output logic [ptr_width(DEPTH):0]   level,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned PtrW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    level_q;
  logic             do_push, do_pop;

  assign full     = (level_q == (PtrW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;

  // Pointers are exactly PtrW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      level_q <= level_q + (PtrW+1)'(1);
      else if (do_pop && !do_push) level_q <= level_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: buffers words in a FIFO and shifts them out one bit per clock,
// streaming back-to-back words without gaps.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       enable,
  input  logic                       flush,
  output logic                       ser_bit,
  output logic                       ser_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] head;
  logic             full, empty, load, last_bit;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (load),
    .pop_data  (head),
    .flush     (flush),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  assign in_ready  = !full && !flush;
  assign last_bit  = (cnt_q == CntW'(1));
  // Refill on the last bit as well as from idle so consecutive words abut.
  assign load      = !flush && enable && !empty && ((state_q == StIdle) || last_bit);
  assign busy      = (state_q == StShift);
  assign ser_valid = (state_q == StShift) && enable;
  assign ser_bit   = !ser_valid ? IDLE_BIT :
                     (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (load) begin
      state_d = StShift;
      sreg_d  = head;
      cnt_d   = CntW'(WIDTH);
    end else if ((state_q == StShift) && enable) begin
      if (last_bit) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        sreg_d = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
